// File: rtl/ffe_pkg.sv
// Shared width derivation, tree sizing and saturation limits for the ffe_pipe equaliser.
package ffe_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned prod_bw(input int unsigned in_bw, input int unsigned coef_bw);
    return in_bw + coef_bw;
  endfunction

  function automatic int unsigned acc_bw(input int unsigned in_bw, input int unsigned coef_bw,
                                         input int unsigned n_coef);
    return prod_bw(in_bw, coef_bw) + clog2(n_coef);
  endfunction

  // Operand count entering tree level lvl (level 0 is the product row).
  function automatic int unsigned lvl_cnt(input int unsigned n, input int unsigned lvl);
    return (n + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  function automatic longint sat_max(input int unsigned out_bw);
    return (longint'(1) << (out_bw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned out_bw);
    return -(longint'(1) << (out_bw - 1));
  endfunction

endpackage

// File: rtl/ffe_add_stage.sv
// One registered adder-tree level: pairwise sums, odd leftover operand registered through.
module ffe_add_stage #(
  parameter int unsigned N_IN = 2,
  parameter int unsigned W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_IN*W-1:0]            ops,
  output logic [((N_IN+1)/2)*W-1:0]    sums
);

  localparam int unsigned N_OUT = (N_IN + 1) / 2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sums <= '0;
    end else begin
      for (int i = 0; i < int'(N_IN / 2); i++) begin
        sums[i*W +: W] <= ops[(2*i)*W +: W] + ops[(2*i+1)*W +: W];
      end
      if ((N_IN % 2) != 0) begin
        sums[(N_OUT-1)*W +: W] <= ops[(N_IN-1)*W +: W];
      end
    end
  end

endmodule

// File: rtl/ffe_pipe.sv
// Pipelined direct-form FFE with valid tracking, atomic coefficient load and saturating output.
// Define FFE_PIPE_ROUND_EN for round-half-up on the output slice; otherwise it truncates.
module ffe_pipe
  import ffe_pkg::*;
#(
  parameter int unsigned IN_BW   = 11,
  parameter int unsigned OUT_BW  = 9,
  parameter int unsigned COEF_BW = 9,
  parameter int unsigned N_COEF  = 7,
  parameter int unsigned OUT_LSB = 7
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [IN_BW-1:0]           i_data,
  input  logic [COEF_BW*N_COEF-1:0]  i_coefs,
  input  logic                       i_coef_upd,
  output logic                       o_valid,
  output logic [OUT_BW-1:0]          o_data,
  output logic                       o_sat
);

  localparam int unsigned LOG2N   = clog2(N_COEF);
  localparam int unsigned PROD_BW = prod_bw(IN_BW, COEF_BW);
  localparam int unsigned ACC_BW  = acc_bw(IN_BW, COEF_BW, N_COEF);
  localparam logic signed [ACC_BW:0] MAXV = (ACC_BW+1)'(sat_max(OUT_BW));
  localparam logic signed [ACC_BW:0] MINV = (ACC_BW+1)'(sat_min(OUT_BW));

  logic signed [COEF_BW-1:0] coef [N_COEF];
  logic signed [IN_BW-1:0]   dly  [1:N_COEF-1];
  logic signed [IN_BW-1:0]   tap  [N_COEF];
  logic signed [PROD_BW-1:0] mult [N_COEF];
  logic [N_COEF*ACC_BW-1:0]  prod;
  logic [LOG2N:0]            vld;
  logic signed [ACC_BW-1:0]  acc;
  logic signed [ACC_BW:0]    ext;
  logic signed [ACC_BW:0]    shifted;
  logic [OUT_BW-1:0]         data_c;
  logic                      sat_c;

  // Active coefficient bank, swapped as a whole.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < int'(N_COEF); k++) coef[k] <= '0;
    end else if (i_coef_upd) begin
      for (int k = 0; k < int'(N_COEF); k++) coef[k] <= i_coefs[k*COEF_BW +: COEF_BW];
    end
  end

  always_comb begin
    tap[0] = i_data;
    for (int k = 1; k < int'(N_COEF); k++) tap[k] = dly[k];
    for (int k = 0; k < int'(N_COEF); k++) mult[k] = PROD_BW'(coef[k]) * PROD_BW'(tap[k]);
  end

  // Delay line and product row advance only on accepted samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 1; k < int'(N_COEF); k++) dly[k] <= '0;
      prod <= '0;
    end else if (i_valid) begin
      dly[1] <= i_data;
      for (int k = 2; k < int'(N_COEF); k++) dly[k] <= dly[k-1];
      for (int k = 0; k < int'(N_COEF); k++) prod[k*ACC_BW +: ACC_BW] <= ACC_BW'(mult[k]);
    end
  end

  for (genvar l = 0; l < int'(LOG2N); l++) begin : g_lvl
    localparam int unsigned NI = lvl_cnt(N_COEF, l);
    localparam int unsigned NO = lvl_cnt(N_COEF, l + 1);
    logic [NO*ACC_BW-1:0] sums;
    if (l == 0) begin : g_first
      ffe_add_stage #(.N_IN(NI), .W(ACC_BW)) u_stage (
        .clk(i_clk), .rst(i_rst), .ops(prod), .sums(sums)
      );
    end else begin : g_rest
      ffe_add_stage #(.N_IN(NI), .W(ACC_BW)) u_stage (
        .clk(i_clk), .rst(i_rst), .ops(g_lvl[l-1].sums), .sums(sums)
      );
    end
  end

  assign acc = g_lvl[LOG2N-1].sums;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) vld <= '0;
    else       vld <= {vld[LOG2N-1:0], i_valid};
  end

  // One guard bit above the accumulator absorbs the rounding increment.
  always_comb begin
    ext = (ACC_BW+1)'(acc);
`ifdef FFE_PIPE_ROUND_EN
    ext = ext + ((ACC_BW+1)'(1) << (OUT_LSB - 1));
`endif
    shifted = ext >>> OUT_LSB;
    sat_c   = 1'b0;
    data_c  = OUT_BW'(shifted);
    if (shifted > MAXV) begin
      data_c = OUT_BW'(MAXV);
      sat_c  = 1'b1;
    end else if (shifted < MINV) begin
      data_c = OUT_BW'(MINV);
      sat_c  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sat   <= 1'b0;
    end else begin
      o_valid <= vld[LOG2N];
      if (vld[LOG2N]) begin
        o_data <= data_c;
        o_sat  <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_ffe_pipe.sv
// Self-checking bench for ffe_pipe: vector table, directed corner sequences and random traffic
// compared against a sample-history reference model.
module tb_ffe_pipe;

  localparam int IN_BW = 11, OUT_BW = 9, COEF_BW = 9, N = 7, OUT_LSB = 7, LAT = 4;
  localparam int MAXO = (1 << (OUT_BW - 1)) - 1;
  localparam int MINO = -(1 << (OUT_BW - 1));

  logic clk = 1'b0;
  logic rst, vin, upd;
  logic signed [IN_BW-1:0] din;
  logic [COEF_BW*N-1:0] coefs;
  logic vout, sat;
  logic signed [OUT_BW-1:0] dout;

  always #5 clk = ~clk;

  ffe_pipe #(.IN_BW(IN_BW), .OUT_BW(OUT_BW), .COEF_BW(COEF_BW), .N_COEF(N), .OUT_LSB(OUT_LSB)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vin), .i_data(din), .i_coefs(coefs),
    .i_coef_upd(upd), .o_valid(vout), .o_data(dout), .o_sat(sat)
  );

  typedef struct { int due; int d; bit s; } exp_t;
  typedef struct { int c0; int d; int ed; bit es; } vec_t;

  int checks = 0, errors = 0, cyc = 0;
  int cm[N], hist[N], cbus[N];
  exp_t eq[$];
  int got_q[$];
  int last_d = 0;
  bit last_s = 1'b0;
  vec_t tbl[13];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Reference output slice: optional half-up rounding, floor shift, clamp.
  function automatic void quantise(input longint acc, output int d, output bit s);
    longint v;
    v = acc;
`ifdef FFE_PIPE_ROUND_EN
    v = v + (longint'(1) << (OUT_LSB - 1));
`endif
    v = v >>> OUT_LSB;
    s = 1'b1;
    if (v > MAXO) d = MAXO;
    else if (v < MINO) d = MINO;
    else begin d = int'(v); s = 1'b0; end
  endfunction

  task automatic drive_bus();
    for (int k = 0; k < N; k++) coefs[k*COEF_BW +: COEF_BW] = COEF_BW'(cbus[k]);
  endtask

  task automatic step(input bit v, input int d, input bit u);
    longint acc;
    exp_t e;
    int qd;
    bit qs, ev;
    vin = v; din = IN_BW'(d); upd = u;
    @(posedge clk);
    cyc++;
    if (v) begin
      for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
      acc = 0;
      for (int k = 0; k < N; k++) acc += longint'(cm[k]) * hist[k];
      quantise(acc, qd, qs);
      eq.push_back('{cyc + LAT, qd, qs});
    end
    if (u) cm = cbus;
    #1;
    ev = (eq.size() > 0) && (eq[0].due == cyc);
    chk("o_valid", vout, ev);
    if (ev) begin
      e = eq.pop_front();
      last_d = e.d;
      last_s = e.s;
    end
    chk("o_data", dout, last_d);
    chk("o_sat", sat, last_s);
    if (vout) got_q.push_back(int'(dout));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0);
  endtask

  task automatic flush();
    repeat (N) step(1'b1, 0, 1'b0);
    idle(LAT);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin cm[k] = 0; hist[k] = 0; end
    eq.delete();
    last_d = 0;
    last_s = 1'b0;
  endtask

  task automatic run_impulse(input string tag);
    int g;
    for (int k = 0; k < N; k++) cbus[k] = k + 1;
    drive_bus();
    step(1'b0, 0, 1'b1);
    flush();
    got_q.delete();
    step(1'b1, 128, 1'b0);
    repeat (N) step(1'b1, 0, 1'b0);
    idle(LAT);
    chk({tag, "_count"}, got_q.size(), N + 1);
    for (int i = 0; i <= N; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 9999;
      chk({tag, "_out"}, g, (i < N) ? i + 1 : 0);
    end
    chk({tag, "_sat"}, sat, 0);
  endtask

  initial begin
    int g, v0, d0;
    // c0, sample, expected o_data, expected o_sat (other taps zero)
    tbl[0]  = '{1, 64,
`ifdef FFE_PIPE_ROUND_EN
                1,
`else
                0,
`endif
                1'b0};
    tbl[1]  = '{1, -64,
`ifdef FFE_PIPE_ROUND_EN
                0,
`else
                -1,
`endif
                1'b0};
    tbl[2]  = '{1, -63,
`ifdef FFE_PIPE_ROUND_EN
                0,
`else
                -1,
`endif
                1'b0};
    tbl[3]  = '{1, 128, 1, 1'b0};
    tbl[4]  = '{3, 100, 2, 1'b0};
    tbl[5]  = '{-1, 65, -1, 1'b0};
    tbl[6]  = '{255, 1023, 255, 1'b1};
    tbl[7]  = '{-256, 1023, -256, 1'b1};
    tbl[8]  = '{255, -1024, -256, 1'b1};
    tbl[9]  = '{255, 128, 255, 1'b0};
    tbl[10] = '{255, 129, 255, 1'b1};
    tbl[11] = '{-256, 128, -256, 1'b0};
    tbl[12] = '{5, 77, 3, 1'b0};

    rst = 1'b1; vin = 1'b0; upd = 1'b0; din = '0; coefs = '0;
    for (int k = 0; k < N; k++) cbus[k] = 0;
    model_reset();
    #2;
    chk("rst_valid", vout, 0);
    chk("rst_data", dout, 0);
    chk("rst_sat", sat, 0);
    #10 rst = 1'b0;

    run_impulse("impulse");

    // Single-tap vector table.
    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < N; k++) cbus[k] = 0;
      cbus[0] = tbl[i].c0;
      drive_bus();
      step(1'b0, 0, 1'b1);
      got_q.delete();
      step(1'b1, tbl[i].d, 1'b0);
      idle(LAT);
      g = (got_q.size() == 1) ? got_q[0] : 9999;
      chk($sformatf("tbl%0d_data", i), g, tbl[i].ed);
      chk($sformatf("tbl%0d_sat", i), sat, tbl[i].es);
    end

    // Saturation with full history.
    for (int k = 0; k < N; k++) cbus[k] = 255;
    drive_bus();
    step(1'b0, 0, 1'b1);
    repeat (N) step(1'b1, 1023, 1'b0);
    idle(LAT);
    chk("satpos_data", dout, 255);
    chk("satpos_sat", sat, 1);
    repeat (N) step(1'b1, -1024, 1'b0);
    idle(LAT);
    chk("satneg_data", dout, -256);
    chk("satneg_sat", sat, 1);

    // Coefficient swap on a valid edge.
    for (int k = 0; k < N; k++) cbus[k] = 0;
    cbus[0] = 1;
    drive_bus();
    step(1'b0, 0, 1'b1);
    flush();
    got_q.delete();
    repeat (6) step(1'b1, 128, 1'b0);
    cbus[0] = 2;
    drive_bus();
    step(1'b1, 128, 1'b1);
    repeat (6) step(1'b1, 128, 1'b0);
    idle(LAT);
    chk("cupd_count", got_q.size(), 13);
    for (int i = 0; i < 13; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 9999;
      chk("cupd_out", g, (i < 7) ? 1 : 2);
    end

    // Back-to-back loads: the later one wins.
    cbus[0] = 3; drive_bus(); step(1'b0, 0, 1'b1);
    cbus[0] = 5; drive_bus(); step(1'b0, 0, 1'b1);
    cbus[0] = 9; drive_bus();
    got_q.delete();
    step(1'b1, 128, 1'b0);
    idle(LAT);
    g = (got_q.size() == 1) ? got_q[0] : 9999;
    chk("b2b_out", g, 5);

    // Valid gaps 1,0,0,1,1 with a multi-tap filter.
    for (int k = 0; k < N; k++) cbus[k] = int'($urandom_range(0, 63)) - 32;
    drive_bus();
    step(1'b0, 0, 1'b1);
    step(1'b1, 300, 1'b0);
    step(1'b0, 77, 1'b0);
    step(1'b0, -500, 1'b0);
    step(1'b1, -200, 1'b0);
    step(1'b1, 900, 1'b0);
    idle(LAT + 2);

    // Asynchronous reset while o_valid is high.
    for (int k = 0; k < N; k++) cbus[k] = k + 1;
    drive_bus();
    step(1'b0, 0, 1'b1);
    repeat (5) step(1'b1, 100, 1'b0);
    chk("prerst_valid", vout, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", vout, 0);
    chk("arst_data", dout, 0);
    chk("arst_sat", sat, 0);
    #1 rst = 1'b0;
    model_reset();
    got_q.delete();
    step(1'b1, 128, 1'b0);
    idle(LAT);
    g = (got_q.size() == 1) ? got_q[0] : 9999;
    chk("postrst_zero", g, 0);
    run_impulse("reimpulse");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < N; k++)
          cbus[k] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 511)) - 256
                                                : int'($urandom_range(0, 63)) - 32;
        drive_bus();
      end
      v0 = ($urandom_range(0, 99) < 70) ? 1 : 0;
      d0 = int'($urandom_range(0, 2047)) - 1024;
      step(v0 != 0, d0, $urandom_range(0, 19) == 0);
    end
    idle(LAT + 1);
    chk("drain_empty", eq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
